fft_butterfly_pipe: RTL and testbench
=====================================

Name: fft_butterfly_pipe

Overview:
Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath.
Computes sum = A + W·B and diff = A − W·B on packed complex words, with:
- rounding instead of truncation;
- optional per-transaction divide-by-2 scaling;
- output saturation with a sticky overflow flag.
It sits between the FFT stage sample buffers and the stage controller, and moves one butterfly per clock through a valid/ready handshake.

Parameters:
DATA_W, 16, width of each real/imag component of A, B, sum, diff (signed Q1.(DATA_W-1))
TW_W, 16, width of each real/imag component of W (signed Q1.(TW_W-1))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  A/B/W/scale valid
in_ready  output  1  pipeline can accept this cycle
in_a  input  2*DATA_W  {real, imag}, real in upper half
in_b  input  2*DATA_W  {real, imag}
in_w  input  2*TW_W  {real, imag} twiddle
in_scale  input  1  1 = divide results by 2 (rounded)
out_valid  output  1  sum/diff valid
out_ready  input  1  downstream accepts
out_sum  output  2*DATA_W  {real, imag} of A + W·B
out_diff  output  2*DATA_W  {real, imag} of A − W·B
ovf  output  1  sticky: any saturated component since last clear
ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: all stage valids 0, out_valid 0, out_sum 0, out_diff 0, ovf 0.
- Reset mid-operation discards all in-flight data.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - While out_valid && !out_ready: the whole pipeline holds, outputs stay stable, and nothing is lost or duplicated.
  - Bubbles propagate as invalid stages.
- Latency is 3 cycles from acceptance to out_valid when there is no back-pressure. Full throughput is one butterfly per cycle.
- S1 (register on accept):
  - p1 = Wr·Br, p2 = Wi·Bi, p3 = Wi·Br, p4 = Wr·Bi, full precision signed (DATA_W+TW_W bits).
  - A and scale are delayed alongside.
- S2:
  - Each p is rounded: rk = (pk + 2^(TW_W-2)) >>> (TW_W-1), arithmetic shift, DATA_W+1 bits.
  - The extra bit holds the (−1)·(−1) = +1 case.
  - WBr = r1 − r2, WBi = r3 + r4, DATA_W+2 bits.
  - Register WBr, WBi, A and scale.
- S3:
  - s = A ± WB per component, DATA_W+3 bits, sign-extended.
  - If scale: s = (s + 1) >>> 1.
  - Saturate to [−2^(DATA_W-1), 2^(DATA_W-1)−1] and register into out_sum/out_diff.
- ovf:
  - Set on the cycle a saturating result is loaded into the outputs.
  - ovf_clr clears it. Set wins over a simultaneous clr.
- All arithmetic is two's complement and explicitly sign-extended. No implicit unsigned mixing.

Decomposition:
- Package fft_pkg holds:
  - DATA_W/TW_W defaults;
  - pack/unpack functions for {real, imag};
  - function round_shift(value, n);
  - function sat(value, width) returning the clipped value and a clip flag.
- One sub-module, cmul_round: S1–S2 complex multiply with rounding. It exposes an advance enable and DATA_W+2-bit real/imag outputs.
- fft_butterfly_pipe instantiates cmul_round and owns S3, the handshake and ovf.

Test Plan:
1. Basic case, out_ready=1, scale=0.
   Stimulus: A={0x1000,0x2000}, B={0x2000,0x0400}, W={0x4000,0x0000}.
   Response: 3 cycles later out_sum={0x2000,0x2200}, out_diff={0x0000,0x1E00}, ovf=0.
2. Saturation, scale=0.
   Stimulus: A={0x7000,0}, B={0x7000,0}, W={0x7FFF,0}.
   Response: out_sum={0x7FFF,0x0000}, out_diff={0x0001,0x0000}, ovf=1. ovf stays 1 until an ovf_clr pulse, then reads 0.
   Same inputs with scale=1: out_sum={0x7000,0}, out_diff={0x0001,0}, ovf stays 0.
3. Corner of the rounding range.
   Stimulus: A=0, B={0x8000,0}, W={0x8000,0}.
   Response: WBr=+0x8000; out_sum real=0x7FFF with ovf=1; out_diff real=0x8000 (not clipped).
4. Back-pressure.
   Stimulus: stream 5 distinct butterflies; drop out_ready for 4 cycles after the first result.
   Response: in_ready=0 during the stall, out_sum/out_diff held constant, and all 5 results emerge in order with none duplicated.
5. Reset mid-operation.
   Stimulus: 2 items in flight; assert rst_n=0 asynchronously between clock edges.
   Response: out_valid=0 and outputs=0 immediately. After release, the first new input appears 3 cycles after acceptance.
6. Simultaneous set and clear.
   Stimulus: a saturating result loads in the same cycle ovf_clr=1.
   Response: ovf=1 afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths, complex-word packing and fixed-point helpers for the FFT datapath.
// Helpers operate on 64-bit signed intermediates; callers narrow with explicit casts.
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned TW_W_DEF   = 16;
  localparam int unsigned WIDE_W     = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;
  typedef logic        [WIDE_W-1:0] word_t;

  typedef struct packed {
    wide_t val;
    logic  clip;
  } sat_t;

  // {re, im} packing; each component is truncated to w bits, real in the upper half.
  function automatic word_t cpack(input wide_t re, input wide_t im, input int unsigned w);
    word_t mask;
    mask = (word_t'(1) << w) - word_t'(1);
    return ((word_t'(re) & mask) << w) | (word_t'(im) & mask);
  endfunction

  function automatic wide_t cunpack_re(input word_t word, input int unsigned w);
    wide_t t;
    t = wide_t'(word << (WIDE_W - 2 * w));
    return t >>> (WIDE_W - w);
  endfunction

  function automatic wide_t cunpack_im(input word_t word, input int unsigned w);
    wide_t t;
    t = wide_t'(word << (WIDE_W - w));
    return t >>> (WIDE_W - w);
  endfunction

  // Round half up, then arithmetic shift right by n.
  function automatic wide_t round_shift(input wide_t v, input int unsigned n);
    if (n == 0) return v;
    return (v + (wide_t'(1) <<< (n - 1))) >>> n;
  endfunction

  function automatic sat_t sat(input wide_t v, input int unsigned w);
    sat_t  res;
    wide_t hi;
    wide_t lo;
    hi       = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo       = -(wide_t'(1) <<< (w - 1));
    res.clip = (v > hi) || (v < lo);
    res.val  = (v > hi) ? hi : ((v < lo) ? lo : v);
    return res;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Two-stage complex multiply W*B: full-precision partial products, then rounded
// recombination into DATA_W+2-bit real/imag. Both stages move only on adv_i.
module cmul_round
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv_i,
  input  logic [2*DATA_W-1:0]      b_i,
  input  logic [2*TW_W-1:0]        w_i,
  output logic signed [DATA_W+1:0] wbr_o,
  output logic signed [DATA_W+1:0] wbi_o
);

  localparam int unsigned P_W  = DATA_W + TW_W;
  localparam int unsigned R_W  = DATA_W + 1;
  localparam int unsigned WB_W = DATA_W + 2;

  logic signed [DATA_W-1:0] br, bi;
  logic signed [TW_W-1:0]   wr, wi;
  logic signed [P_W-1:0]    p1_d, p2_d, p3_d, p4_d;
  logic signed [P_W-1:0]    p1_q, p2_q, p3_q, p4_q;
  logic signed [R_W-1:0]    r1, r2, r3, r4;
  logic signed [WB_W-1:0]   wbr_d, wbi_d, wbr_q, wbi_q;

  always_comb begin
    br   = DATA_W'(cunpack_re(word_t'(b_i), DATA_W));
    bi   = DATA_W'(cunpack_im(word_t'(b_i), DATA_W));
    wr   = TW_W'(cunpack_re(word_t'(w_i), TW_W));
    wi   = TW_W'(cunpack_im(word_t'(w_i), TW_W));
    p1_d = P_W'(wr) * P_W'(br);
    p2_d = P_W'(wi) * P_W'(bi);
    p3_d = P_W'(wi) * P_W'(br);
    p4_d = P_W'(wr) * P_W'(bi);
  end

  // The extra rounded bit keeps (-1)*(-1) = +1 representable.
  always_comb begin
    r1    = R_W'(round_shift(wide_t'(p1_q), TW_W - 1));
    r2    = R_W'(round_shift(wide_t'(p2_q), TW_W - 1));
    r3    = R_W'(round_shift(wide_t'(p3_q), TW_W - 1));
    r4    = R_W'(round_shift(wide_t'(p4_q), TW_W - 1));
    wbr_d = WB_W'(r1) - WB_W'(r2);
    wbi_d = WB_W'(r3) + WB_W'(r4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q  <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
      p4_q  <= '0;
      wbr_q <= '0;
      wbi_q <= '0;
    end else if (adv_i) begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      p3_q  <= p3_d;
      p4_q  <= p4_d;
      wbr_q <= wbr_d;
      wbi_q <= wbi_d;
    end
  end

  assign wbr_o = wbr_q;
  assign wbi_o = wbi_q;

endmodule

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: sum = A + W*B, diff = A - W*B, with rounding,
// optional /2 scaling, output saturation and a sticky overflow flag.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TW_W   = TW_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   in_w,
  input  logic                in_scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_sum,
  output logic [2*DATA_W-1:0] out_diff,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int unsigned PAY_W = 2 * DATA_W;
  localparam int unsigned WB_W  = DATA_W + 2;
  localparam int unsigned S_W   = DATA_W + 3;

  logic                  advance;
  logic                  v1_q, v2_q, out_valid_q;
  logic [PAY_W-1:0]      a1_q, a2_q;
  logic                  sc1_q, sc2_q;
  logic signed [WB_W-1:0] wbr, wbi;
  logic signed [S_W-1:0] a_re, a_im, wb_re, wb_im;
  logic signed [S_W-1:0] s_c [4];
  sat_t                  r_c [4];
  logic                  clip_any;
  logic [PAY_W-1:0]      sum_d, diff_d, sum_q, diff_q;
  logic                  ovf_d, ovf_q;

  // The whole pipeline stalls only when a valid result is not being taken.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  cmul_round #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (advance),
    .b_i   (in_b),
    .w_i   (in_w),
    .wbr_o (wbr),
    .wbi_o (wbi)
  );

  // S3: combine, optional rounded halving, clip to DATA_W.
  always_comb begin
    a_re     = S_W'(cunpack_re(word_t'(a2_q), DATA_W));
    a_im     = S_W'(cunpack_im(word_t'(a2_q), DATA_W));
    wb_re    = S_W'(wbr);
    wb_im    = S_W'(wbi);
    s_c[0]   = a_re + wb_re;
    s_c[1]   = a_im + wb_im;
    s_c[2]   = a_re - wb_re;
    s_c[3]   = a_im - wb_im;
    clip_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_c[k]   = sat(sc2_q ? round_shift(wide_t'(s_c[k]), 1) : wide_t'(s_c[k]), DATA_W);
      clip_any = clip_any | r_c[k].clip;
    end
    sum_d  = PAY_W'(cpack(r_c[0].val, r_c[1].val, DATA_W));
    diff_d = PAY_W'(cpack(r_c[2].val, r_c[3].val, DATA_W));
  end

  // A saturating load takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (advance && v2_q && clip_any) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      sc1_q       <= 1'b0;
      sc2_q       <= 1'b0;
      sum_q       <= '0;
      diff_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (advance) begin
        v1_q        <= in_valid;
        a1_q        <= in_a;
        sc1_q       <= in_scale;
        v2_q        <= v1_q;
        a2_q        <= a1_q;
        sc2_q       <= sc1_q;
        out_valid_q <= v2_q;
        if (v2_q) begin
          sum_q  <= sum_d;
          diff_q <= diff_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_diff  = diff_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Scoreboard bench for fft_butterfly_pipe: directed butterflies with hand-computed
// results queued at acceptance and checked by an independent output monitor.
module tb_fft_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] in_w = '0;
  logic        in_scale = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic [31:0] out_diff;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.DATA_W(16), .TW_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .in_scale  (in_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic        lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   n0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output monitor: an item is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_output: got sum %h diff %h expected no output", out_sum, out_diff);
      end else begin
        m_e = q.pop_front();
        chk("out_sum", 64'(out_sum), 64'(m_e.s));
        chk("out_diff", 64'(out_diff), 64'(m_e.d));
        if (m_e.lat) chk("latency", 64'(cyc - m_e.issue), 64'd3);
      end
      n_out++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                      input logic sc, input logic [31:0] es, input logic [31:0] ed,
                      input logic lat);
    exp_t e;
    bit   acc;
    acc      = 1'b0;
    in_a     = a;
    in_b     = b;
    in_w     = w;
    in_scale = sc;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s     = es;
        e.d     = ed;
        e.lat   = lat;
        e.issue = cyc;
        q.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_diff", 64'(out_diff), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic butterfly, W = 0.5
    send(32'h1000_2000, 32'h2000_0400, 32'h4000_0000, 1'b0, 32'h2000_2200, 32'h0000_1E00, 1'b1);
    drain();
    chk("basic_ovf", 64'(ovf), 64'd0);

    // Saturation and sticky flag
    send(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000, 1'b1);
    drain();
    chk("sat_ovf_set", 64'(ovf), 64'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("sat_ovf_sticky", 64'(ovf), 64'd1);
    pulse_clr();
    chk("ovf_cleared", 64'(ovf), 64'd0);
    send(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b1, 32'h7000_0000, 32'h0001_0000, 1'b1);
    drain();
    chk("scaled_no_ovf", 64'(ovf), 64'd0);

    // (-1)*(-1) corner
    send(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h7FFF_0000, 32'h8000_0000, 1'b1);
    drain();
    chk("corner_ovf", 64'(ovf), 64'd1);
    pulse_clr();

    // Rounding of the scale step and of the product
    send(32'h0003_FFFD, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0002_FFFF, 32'h0002_FFFF, 1'b1);
    send(32'hFFFF_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    send(32'h0000_0000, 32'h0003_FFFD, 32'h4000_0000, 1'b0, 32'h0002_FFFF, 32'hFFFE_0001, 1'b1);
    drain();
    chk("round_ovf", 64'(ovf), 64'd0);

    // Back-pressure: 5 streamed butterflies, 4-cycle stall after the first result
    n0 = n_out;
    fork
      begin
        send(32'h0100_0200, 32'h0200_0400, 32'h4000_0000, 1'b0, 32'h0200_0400, 32'h0000_0000, 1'b0);
        send(32'h0300_0000, 32'h0000_0100, 32'h4000_0000, 1'b0, 32'h0300_0080, 32'h0300_FF80, 1'b0);
        send(32'hF000_1000, 32'h2000_E000, 32'h4000_0000, 1'b0, 32'h0000_0000, 32'hE000_2000, 1'b0);
        send(32'h1000_1000, 32'h0400_0800, 32'h0000_4000, 1'b0, 32'h0C00_1200, 32'h1400_0E00, 1'b0);
        send(32'h0000_0000, 32'h0003_FFFD, 32'h4000_0000, 1'b0, 32'h0002_FFFF, 32'hFFFE_0001, 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
          n_checks++;
          $display("FAIL stall_wait: got out_valid 0 expected 1");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_sum_held", 64'(out_sum), 64'h0300_0080);
          chk("stall_diff_held", 64'(out_diff), 64'h0300_FF80);
          if (k < 3) @(posedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(n_out - n0), 64'd5);

    // Saturating load coincides with ovf_clr
    chk("pre_setclr_ovf", 64'(ovf), 64'd0);
    send(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000, 1'b1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("set_wins_ovf", 64'(ovf), 64'd1);
    drain();

    // Asynchronous reset with two items in flight
    send(32'h1000_2000, 32'h2000_0400, 32'h4000_0000, 1'b0, 32'h2000_2200, 32'h0000_1E00, 1'b0);
    send(32'h0300_0000, 32'h0000_0100, 32'h4000_0000, 1'b0, 32'h0300_0080, 32'h0300_FF80, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    chk("midrst_out_diff", 64'(out_diff), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h1000_2000, 32'h2000_0400, 32'h4000_0000, 1'b0, 32'h2000_2200, 32'h0000_1E00, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
